// File: rtl/btn_press_fsm.sv
// Multi-channel button front end: tick-enabled debounce, short/long press detection and LED toggle.
// Optional input synchronizer enabled with `define BTN_SYNC_EN.
module btn_press_fsm #(
    parameter int CHANNELS       = 4,
    parameter int TICK_DIV       = 500000,
    parameter int DEBOUNCE_TICKS = 2,
    parameter int LONG_TICKS     = 100
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] btn,
    output logic [CHANNELS-1:0] held,
    output logic [CHANNELS-1:0] short_pulse,
    output logic [CHANNELS-1:0] long_pulse,
    output logic [CHANNELS-1:0] led
);

    localparam int MAX_TICKS = (DEBOUNCE_TICKS > LONG_TICKS) ? DEBOUNCE_TICKS : LONG_TICKS;
    localparam int CW        = $clog2(MAX_TICKS + 1);
    localparam int PW        = $clog2(TICK_DIV);

    // The IDLE sample counts as the first high sample, so DEBOUNCE finishes one count early.
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_TICKS - 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DEBOUNCE = 3'd1,
        PRESSED  = 3'd2,
        LONG     = 3'd3
    } state_t;

    logic [PW-1:0]       prescale;
    logic                tick;
    logic [CHANNELS-1:0] s;

    state_t              state      [CHANNELS];
    state_t              state_next [CHANNELS];
    logic [CW-1:0]       cnt        [CHANNELS];
    logic [CW-1:0]       cnt_next   [CHANNELS];
    logic [CHANNELS-1:0] held_next;
    logic [CHANNELS-1:0] short_next;
    logic [CHANNELS-1:0] long_next;
    logic [CHANNELS-1:0] led_next;

    assign tick = (prescale == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescale <= '0;
        end else if (tick) begin
            prescale <= '0;
        end else begin
            prescale <= prescale + PW'(1);
        end
    end

`ifdef BTN_SYNC_EN
    logic [CHANNELS-1:0] sync_a;
    logic [CHANNELS-1:0] sync_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
        end
    end

    assign s = sync_b;
`else
    assign s = btn;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                state[ch] <= IDLE;
                cnt[ch]   <= '0;
            end
            held        <= '0;
            short_pulse <= '0;
            long_pulse  <= '0;
            led         <= '0;
        end else begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                state[ch] <= state_next[ch];
                cnt[ch]   <= cnt_next[ch];
            end
            held        <= held_next;
            short_pulse <= short_next;
            long_pulse  <= long_next;
            led         <= led_next;
        end
    end

    // Pulses are only raised on a tick cycle, so the registered strobe lasts one clk.
    always_comb begin
        held_next  = '0;
        short_next = '0;
        long_next  = '0;
        led_next   = led;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            state_next[ch] = state[ch];
            cnt_next[ch]   = cnt[ch];
            if (tick) begin
                case (state[ch])
                    IDLE: begin
                        if (s[ch]) begin
                            if (DEBOUNCE_TICKS == 1) begin
                                state_next[ch] = PRESSED;
                                cnt_next[ch]   = '0;
                            end else begin
                                state_next[ch] = DEBOUNCE;
                                cnt_next[ch]   = CW'(1);
                            end
                        end
                    end
                    DEBOUNCE: begin
                        if (!s[ch]) begin
                            state_next[ch] = IDLE;
                            cnt_next[ch]   = '0;
                        end else if (cnt[ch] == DEB_LAST) begin
                            state_next[ch] = PRESSED;
                            cnt_next[ch]   = '0;
                        end else begin
                            cnt_next[ch] = cnt[ch] + CW'(1);
                        end
                    end
                    PRESSED: begin
                        if (!s[ch]) begin
                            state_next[ch] = IDLE;
                            cnt_next[ch]   = '0;
                            short_next[ch] = 1'b1;
                        end else if (cnt[ch] == LONG_LAST) begin
                            state_next[ch] = LONG;
                            cnt_next[ch]   = '0;
                            long_next[ch]  = 1'b1;
                        end else begin
                            cnt_next[ch] = cnt[ch] + CW'(1);
                        end
                    end
                    LONG: begin
                        if (!s[ch]) begin
                            state_next[ch] = IDLE;
                            cnt_next[ch]   = '0;
                        end
                    end
                    default: begin
                        state_next[ch] = IDLE;
                        cnt_next[ch]   = '0;
                    end
                endcase
            end
            held_next[ch] = (state_next[ch] == PRESSED) || (state_next[ch] == LONG);
            if (short_next[ch]) begin
                led_next[ch] = ~led[ch];
            end else if (long_next[ch]) begin
                led_next[ch] = 1'b0;
            end
        end
    end

endmodule
